// File: rtl/nivel_hambre.sv
// nivel_hambre: debounces the food button into a one-cycle feed pulse and keeps the 2-bit hunger level.
// Latency: feed pulse DEBOUNCE_CYCLES+3 edges after boton_raw settles high; nivel/hambre update on the pulse edge.
// No backpressure: outputs are free-running registers. Optional feed lockout enabled by defining FEED_LOCKOUT_EN.
module nivel_hambre #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DECAY_CYCLES    = 250000000,
  parameter int NIVEL_INICIAL   = 3,
  parameter int LOCKOUT_CYCLES  = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton_raw,
  output logic       pulso_comida,
  output logic [1:0] nivel,
  output logic       hambre,
  output logic       bloqueo
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DC_W = $clog2(DECAY_CYCLES);

  localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DC_W-1:0] DC_LAST   = DC_W'(DECAY_CYCLES - 1);
  localparam logic [1:0]      NIVEL_RST = 2'(NIVEL_INICIAL);

  // Debounce FSM encoding
  localparam logic [1:0] SUELTO           = 2'd0;
  localparam logic [1:0] CONFIRMA_PRESION = 2'd1;
  localparam logic [1:0] PRESIONADO       = 2'd2;
  localparam logic [1:0] CONFIRMA_LIBERA  = 2'd3;

  // Counters need at least one bit each; reject configurations that would collapse them.
  if (DEBOUNCE_CYCLES < 1 || DECAY_CYCLES < 2 || LOCKOUT_CYCLES < 2 ||
      NIVEL_INICIAL < 0 || NIVEL_INICIAL > 3) begin : g_bad_cfg
    $error("nivel_hambre: unsupported parameter values");
  end

  logic            s1;
  logic            s2;
  logic [1:0]      state;
  logic [DB_W-1:0] db_cnt;
  logic [DC_W-1:0] dc_cnt;
  logic [DC_W-1:0] dc_next;
  logic [1:0]      nivel_next;
  logic            feed_req;
  logic            feed_ok;

  // Two-flop synchronizer for the asynchronous button; everything downstream looks at s2 only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= boton_raw;
      s2 <= s1;
    end
  end

  // Debounce FSM: a level must hold for DEBOUNCE_CYCLES counted cycles to be accepted;
  // reset parks in PRESIONADO so a button held through reset needs a full release first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= PRESIONADO;
      db_cnt <= '0;
    end else begin
      case (state)
        SUELTO: begin
          if (s2) begin
            state  <= CONFIRMA_PRESION;
            db_cnt <= '0;
          end
        end
        CONFIRMA_PRESION: begin
          if (!s2) begin
            state <= SUELTO;
          end else if (db_cnt == DB_MAX) begin
            state <= PRESIONADO;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        PRESIONADO: begin
          if (!s2) begin
            state  <= CONFIRMA_LIBERA;
            db_cnt <= '0;
          end
        end
        CONFIRMA_LIBERA: begin
          if (s2) begin
            state <= PRESIONADO;
          end else if (db_cnt == DB_MAX) begin
            state <= SUELTO;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: begin
          state  <= PRESIONADO;
          db_cnt <= '0;
        end
      endcase
    end
  end

  // The press is confirmed on the same cycle the FSM leaves CONFIRMA_PRESION for PRESIONADO.
  assign feed_req = (state == CONFIRMA_PRESION) && s2 && (db_cnt == DB_MAX);

`ifdef FEED_LOCKOUT_EN
  localparam int              LK_W    = $clog2(LOCKOUT_CYCLES);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCKOUT_CYCLES - 1);

  logic [LK_W-1:0] lk_cnt;
  logic            bloqueo_q;

  assign feed_ok = feed_req && !bloqueo_q;
  assign bloqueo = bloqueo_q;

  // Lockout window: bloqueo rises with the accepted pulse and drops exactly LOCKOUT_CYCLES edges later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bloqueo_q <= 1'b0;
      lk_cnt    <= '0;
    end else if (feed_ok) begin
      bloqueo_q <= 1'b1;
      lk_cnt    <= '0;
    end else if (bloqueo_q) begin
      if (lk_cnt == LK_LAST) begin
        bloqueo_q <= 1'b0;
      end else begin
        lk_cnt <= lk_cnt + LK_W'(1);
      end
    end
  end
`else
  assign feed_ok = feed_req;
  assign bloqueo = 1'b0;
`endif

  // Next level and decay count; an accepted feed beats a coincident terminal count.
  always_comb begin
    nivel_next = nivel;
    dc_next    = dc_cnt + DC_W'(1);
    if (feed_ok) begin
      dc_next = '0;
      if (nivel != 2'd3) begin
        nivel_next = nivel + 2'd1;
      end
    end else if (dc_cnt == DC_LAST) begin
      dc_next = '0;
      if (nivel != 2'd0) begin
        nivel_next = nivel - 2'd1;
      end
    end
  end

  // Output registers; hambre is derived from the next level so it never lags nivel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      nivel        <= NIVEL_RST;
      hambre       <= (NIVEL_RST == 2'd0);
      dc_cnt       <= '0;
      pulso_comida <= 1'b0;
    end else begin
      nivel        <= nivel_next;
      hambre       <= (nivel_next == 2'd0);
      dc_cnt       <= dc_next;
      pulso_comida <= feed_ok;
    end
  end

endmodule

// File: tb/tb_nivel_hambre.sv
// Bench for nivel_hambre with DEBOUNCE=4, DECAY=20, LOCKOUT=30, NIVEL_INICIAL=3.
// Edge 1 is the first rising edge with reset released; outputs sampled 1 time unit after each edge.
// Table rows run N cycles with a button pattern, then compare pulse count and outputs.
module tb_nivel_hambre;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       boton_raw = 1'b0;
  logic       pulso_comida;
  logic [1:0] nivel;
  logic       hambre;
  logic       bloqueo;

  nivel_hambre #(
    .DEBOUNCE_CYCLES(4),
    .DECAY_CYCLES(20),
    .NIVEL_INICIAL(3),
    .LOCKOUT_CYCLES(30)
  ) dut (
    .clk(clk),
    .reset(reset),
    .boton_raw(boton_raw),
    .pulso_comida(pulso_comida),
    .nivel(nivel),
    .hambre(hambre),
    .bloqueo(bloqueo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int pulses = 0;
  int first_pulse_edge = -1;
  int last_pulse_edge = -1;
  int bloq_cnt = 0;

  // mode: 0 = low, 1 = high, 2 = toggle every 2 cycles starting high
  typedef struct {
    bit do_rst;
    int ncyc;
    int mode;
    int exp_pulses;
    int exp_nivel;
    bit exp_hambre;
    bit exp_pulso;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    if (pulso_comida === 1'b1) begin
      pulses++;
      if (first_pulse_edge < 0) first_pulse_edge = edge_n;
      last_pulse_edge = edge_n;
    end
    if (bloqueo === 1'b1) bloq_cnt++;
  endtask

  task automatic run(input int n, input bit b);
    boton_raw = b;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    chk("rst_pulso", int'(pulso_comida), 0);
    chk("rst_nivel", int'(nivel), 3);
    chk("rst_hambre", int'(hambre), 0);
    chk("rst_bloqueo", int'(bloqueo), 0);
    reset = 1'b1;
    edge_n = 0;
    pulses = 0;
    first_pulse_edge = -1;
    last_pulse_edge = -1;
    bloq_cnt = 0;
  endtask

  initial begin
    // Decay only: 3->2->1->0 at edges 20/40/60, still 0 at 80
    tbl[0]  = '{1, 19, 0, 0, 3, 0, 0};
    tbl[1]  = '{0,  1, 0, 0, 2, 0, 0};
    tbl[2]  = '{0, 19, 0, 0, 2, 0, 0};
    tbl[3]  = '{0,  1, 0, 0, 1, 0, 0};
    tbl[4]  = '{0, 19, 0, 0, 1, 0, 0};
    tbl[5]  = '{0,  1, 0, 0, 0, 1, 0};
    tbl[6]  = '{0, 20, 0, 0, 0, 1, 0};
    // Bouncing press at nivel 1: toggles edges 25..44, held from 45, pulse at 52, next decay at 72
    tbl[7]  = '{1, 24, 0, 0, 2, 0, 0};
    tbl[8]  = '{0, 20, 2, 0, 1, 0, 0};
    tbl[9]  = '{0,  7, 1, 0, 1, 0, 0};
    tbl[10] = '{0,  1, 1, 1, 2, 0, 1};
    tbl[11] = '{0, 19, 1, 0, 2, 0, 0};
    tbl[12] = '{0,  1, 1, 0, 1, 0, 0};
    // Feed at nivel 3: press from edge 6, pulse at 13, nivel saturates, next decay at 33
    tbl[13] = '{1,  5, 0, 0, 3, 0, 0};
    tbl[14] = '{0,  7, 1, 0, 3, 0, 0};
    tbl[15] = '{0,  1, 1, 1, 3, 0, 1};
    tbl[16] = '{0, 19, 0, 0, 3, 0, 0};
    tbl[17] = '{0,  1, 0, 0, 2, 0, 0};
    // Feed coincides with terminal count at edge 40 (nivel 2): feed wins, next decay at 60
    tbl[18] = '{1, 32, 0, 0, 2, 0, 0};
    tbl[19] = '{0,  7, 1, 0, 2, 0, 0};
    tbl[20] = '{0,  1, 1, 1, 3, 0, 1};
    tbl[21] = '{0, 19, 0, 0, 3, 0, 0};
    tbl[22] = '{0,  1, 0, 0, 2, 0, 0};

    for (int r = 0; r < 23; r++) begin
      int p0;
      if (tbl[r].do_rst) begin
        boton_raw = 1'b0;
        do_reset();
      end
      p0 = pulses;
      for (int i = 0; i < tbl[r].ncyc; i++) begin
        case (tbl[r].mode)
          0:       boton_raw = 1'b0;
          1:       boton_raw = 1'b1;
          default: boton_raw = (((i / 2) % 2) == 0);
        endcase
        step();
      end
      chk($sformatf("row%0d_pulses", r), pulses - p0, tbl[r].exp_pulses);
      chk($sformatf("row%0d_nivel", r), int'(nivel), tbl[r].exp_nivel);
      chk($sformatf("row%0d_hambre", r), int'(hambre), int'(tbl[r].exp_hambre));
      chk($sformatf("row%0d_pulso", r), int'(pulso_comida), int'(tbl[r].exp_pulso));
    end

    // Button held through reset release: no pulse until released and pressed again
    boton_raw = 1'b1;
    do_reset();
    run(20, 1'b1);
    chk("held_rst_no_pulse", pulses, 0);
    run(8, 1'b0);
    chk("held_rst_release_no_pulse", pulses, 0);
    begin
      int h;
      h = edge_n + 1;
      run(20, 1'b1);
      chk("repress_pulse_count", pulses, 1);
      chk("repress_latency", first_pulse_edge - h, 7);
    end

    // Reset asserted mid-confirmation with the button still held: aborts, no pulse
    boton_raw = 1'b0;
    do_reset();
    run(6, 1'b0);
    run(4, 1'b1);
    do_reset();
    run(20, 1'b1);
    chk("mid_confirm_reset_no_pulse", pulses, 0);

    // Two presses 15 cycles apart: pulses at 14 and 29 unless locked out
    boton_raw = 1'b0;
    do_reset();
    run(6, 1'b0);
    run(8, 1'b1);
    run(7, 1'b0);
    run(8, 1'b1);
    run(11, 1'b0);
`ifdef FEED_LOCKOUT_EN
    chk("two_press_nivel_e40", int'(nivel), 2);
`else
    chk("two_press_nivel_e40", int'(nivel), 3);
`endif
    run(10, 1'b0);
    chk("two_press_first_edge", first_pulse_edge, 14);
`ifdef FEED_LOCKOUT_EN
    chk("two_press_pulses", pulses, 1);
    chk("two_press_last_edge", last_pulse_edge, 14);
    chk("two_press_bloqueo_cycles", bloq_cnt, 30);
`else
    chk("two_press_pulses", pulses, 2);
    chk("two_press_last_edge", last_pulse_edge, 29);
    chk("two_press_bloqueo_cycles", bloq_cnt, 0);
`endif
    chk("two_press_bloqueo_end", int'(bloqueo), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nivel_hambre.md
# nivel_hambre

Upstream conditioning stage for the pet state machine. It debounces the raw food push-button into a single-cycle feed pulse, which the state machine consumes as `Boton_Comida`. It also maintains the 2-bit hunger level, which the state machine consumes as `Nivel`. The level decays on a fixed period and is raised by accepted feed events.

## Interface
- `DEBOUNCE_CYCLES`, 50000: consecutive stable synchronized cycles needed to accept a press or release.
- `DECAY_CYCLES`, 250000000: clock cycles per one-step level decay.
- `NIVEL_INICIAL`, 3: level loaded at reset (0..3).
- `LOCKOUT_CYCLES`, 100000000: feed lockout length; used only with `FEED_LOCKOUT_EN`.
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: one clock; reset is synchronous and active-low.
- `boton_raw` input 1: asynchronous, bouncing food button; high = pressed.
- `pulso_comida` output 1: one-cycle accepted feed pulse, drives `Boton_Comida`.
- `nivel` output 2: hunger level, 3 = full, 0 = starving; drives `Nivel`.
- `hambre` output 1: high while `nivel == 0`.
- `bloqueo` output 1: high while the feed lockout is active.

## Operation
- Synchronizer: two flops `boton_raw`→s1→s2. All other logic uses s2 only.
- Debounce FSM states:
  - SUELTO: s2=1 → CONFIRMA_PRESION, count cleared.
  - CONFIRMA_PRESION: s2=0 → SUELTO; count reaches DEBOUNCE_CYCLES → PRESIONADO and raise a feed request.
  - PRESIONADO: s2=0 → CONFIRMA_LIBERA, count cleared.
  - CONFIRMA_LIBERA: s2=1 → PRESIONADO; count reaches DEBOUNCE_CYCLES → SUELTO.
- Reset state is PRESIONADO. A button held through reset release produces no pulse until it is released and pressed again.
- Debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)`. Decay counter width is `$clog2(DECAY_CYCLES)`.
- Feed request accepted:
  - `pulso_comida`=1 for exactly one cycle.
  - `nivel` increments, saturating at 3.
  - Decay counter clears to 0.
- Decay counter runs 0..DECAY_CYCLES-1 continuously. On terminal count it wraps to 0 and `nivel` decrements, saturating at 0. It keeps running at level 0.
- Feed and terminal count in the same cycle: the feed wins. `nivel` = min(nivel+1, 3), counter cleared, no decrement.
- `hambre` is registered and consistent with `nivel` on every cycle.

## Timing
- Reset values:
  - `pulso_comida`=0, `bloqueo`=0.
  - `nivel`=NIVEL_INICIAL, `hambre`=(NIVEL_INICIAL==0).
  - FSM in PRESIONADO, all counters 0.
- Press latency: with `boton_raw` stable high from edge k, `pulso_comida` is high on edge k+DEBOUNCE_CYCLES+3.
- `nivel` updates on the same edge that `pulso_comida` rises.
- Decay: with no feed, `nivel` steps down every DECAY_CYCLES cycles. The first step lands DECAY_CYCLES edges after reset release or after the last accepted feed.
- Any bounce (s2 change) before the count completes restarts confirmation. At most one pulse is produced per debounced press.
- Reset asserted mid-confirmation aborts the operation with no pulse; reset takes priority over every event.

## Configuration
- `FEED_LOCKOUT_EN` defined:
  - Each accepted feed starts a LOCKOUT_CYCLES lockout and sets `bloqueo`=1.
  - Debounced presses during lockout are discarded: no pulse, no level change, no decay-counter clear.
  - `bloqueo` falls after exactly LOCKOUT_CYCLES cycles.
- `FEED_LOCKOUT_EN` undefined: lockout logic absent, `bloqueo` tied 0, every debounced press is accepted.

## Test plan
Parameters: DEBOUNCE_CYCLES=4, DECAY_CYCLES=20, LOCKOUT_CYCLES=30, NIVEL_INICIAL=3.
- Reset, `boton_raw`=0, run 80 cycles → `nivel` 3→2→1→0 at edges 20/40/60; `hambre`=1 from edge 60; `nivel` still 0 at edge 80.
- `boton_raw` toggles every 2 cycles for 20 cycles, then held high, at `nivel`=1 → exactly one `pulso_comida`, `nivel`=2.
- Feed at `nivel`=3 → one pulse, `nivel` stays 3, next decrement exactly 20 cycles after the pulse.
- Press timed so acceptance coincides with decay terminal count at `nivel`=2 → `nivel`=3, no decrement, next decay 20 cycles later.
- `boton_raw` held high through reset release → no pulse; release for 8 cycles, press again → one pulse at latency 7.
- Two presses 15 cycles apart: macro defined → one pulse, `bloqueo` high for 30 cycles; macro undefined → two pulses, `bloqueo`=0.
